// File: rtl/bike_light_pkg.sv
// Shared mode codes, press-event encoding and mode transition
// function for the single-button bike light controller.
package bike_light_pkg;

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_CONST = 3'd1;
  localparam logic [2:0] MODE_SLOW  = 3'd2;
  localparam logic [2:0] MODE_FAST  = 3'd3;
  localparam logic [2:0] MODE_CHASE = 3'd4;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_SHORT = 2'd1,
    EV_LONG  = 2'd2
  } press_ev_e;

  function automatic logic [2:0] next_mode(
    input logic [2:0] cur,
    input press_ev_e  ev
  );
    logic [2:0] nm;
    nm = cur;
    case (cur)
      MODE_OFF:   if (ev == EV_LONG) nm = MODE_CONST;
      MODE_CONST: if (ev == EV_LONG) nm = MODE_OFF;
                  else if (ev == EV_SHORT) nm = MODE_SLOW;
      MODE_SLOW:  if (ev == EV_LONG) nm = MODE_OFF;
                  else if (ev == EV_SHORT) nm = MODE_FAST;
      MODE_FAST:  if (ev == EV_LONG) nm = MODE_OFF;
                  else if (ev == EV_SHORT) nm = MODE_CHASE;
      MODE_CHASE: if (ev == EV_LONG) nm = MODE_OFF;
                  else if (ev == EV_SHORT) nm = MODE_CONST;
      default:    nm = MODE_OFF;
    endcase
    return nm;
  endfunction

endpackage

// File: rtl/bike_light_ctrl_press.sv
// Button front end: periodic debounce sampling, hold counter and
// one-cycle short/long press strobes.
module button_press_detect
  import bike_light_pkg::*;
#(
  parameter int DEB_CYC  = 50000,
  parameter int LONG_CYC = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic short_p,
  output logic long_p
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 1);

  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          sb_q, sb_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          tick;

  always_comb begin
    tick   = (deb_q == DEB_LAST);
    deb_d  = tick ? '0 : deb_q + DW'(1);
    sb_d   = tick ? button : sb_q;
    hold_d = hold_q;
    if (!sb_q)
      hold_d = '0;
    else if (hold_q != HOLD_MAX)
      hold_d = hold_q + HW'(1);
    long_d  = sb_q && (hold_q == HOLD_PRE);
    // hold_q keeps the released count for exactly one cycle after sb falls
    short_d = !sb_q && (hold_q != '0) && (hold_q != HOLD_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q   <= '0;
      hold_q  <= '0;
      sb_q    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      sb_q    <= sb_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign short_p = short_q;
  assign long_p  = long_q;

endmodule

// File: rtl/bike_light_ctrl.sv
// Bike light controller: mode FSM, flash/chase/PWM timers and the
// registered LED drive for a single-button lamp bar.
module bike_light_ctrl
  import bike_light_pkg::*;
#(
  parameter int LED_W     = 3,
  parameter int DEB_CYC   = 50000,
  parameter int LONG_CYC  = 10000000,
  parameter int SLOW_HALF = 1666667,
  parameter int FAST_HALF = 625000,
  parameter int PWM_BITS  = 4,
  parameter int DIM_DUTY  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button,
  input  logic             batt_low,
  output logic [LED_W-1:0] light,
  output logic [2:0]       mode
);

  localparam int SW  = $clog2(2 * SLOW_HALF);
  localparam int FW  = $clog2(2 * FAST_HALF);
  localparam int CW  = $clog2(LED_W);
  localparam int PW1 = PWM_BITS + 1;
  localparam logic [SW-1:0] SLOW_LAST = SW'(2 * SLOW_HALF - 1);
  localparam logic [SW-1:0] SLOW_MID  = SW'(SLOW_HALF);
  localparam logic [FW-1:0] FAST_LAST = FW'(2 * FAST_HALF - 1);
  localparam logic [FW-1:0] FAST_MID  = FW'(FAST_HALF);
  localparam logic [CW-1:0] CHASE_LAST = CW'(LED_W - 1);
  localparam logic [PW1-1:0] DUTY = PW1'(DIM_DUTY);
  localparam logic [LED_W-1:0] ONE = LED_W'(1);

  logic          short_p, long_p;
  press_ev_e     ev;

  logic [2:0]          mode_q, mode_d;
  logic [SW-1:0]       slow_q, slow_d;
  logic [FW-1:0]       fast_q, fast_d;
  logic [CW-1:0]       chase_q, chase_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                bs1_q, bs2_q;
  logic [LED_W-1:0]    light_q, light_d;
  logic [LED_W-1:0]    raw;
  logic                slow_on, fast_on, en;

  button_press_detect #(
    .DEB_CYC (DEB_CYC),
    .LONG_CYC(LONG_CYC)
  ) u_press (
    .clock  (clock),
    .reset  (reset),
    .button (button),
    .short_p(short_p),
    .long_p (long_p)
  );

  always_comb begin
    ev     = long_p ? EV_LONG : (short_p ? EV_SHORT : EV_NONE);
    mode_d = next_mode(mode_q, ev);
    slow_d = (slow_q == SLOW_LAST) ? '0 : slow_q + SW'(1);
    fast_d = (fast_q == FAST_LAST) ? '0 : fast_q + FW'(1);
    pwm_d  = pwm_q + PWM_BITS'(1);

    // chase steps every FAST_HALF cycles; entering CHASE restarts it
    chase_d = chase_q;
    if (mode_d == MODE_CHASE && mode_q != MODE_CHASE)
      chase_d = '0;
    else if (fast_d == '0 || fast_d == FAST_MID)
      chase_d = (chase_q == CHASE_LAST) ? '0 : chase_q + CW'(1);

    slow_on = (slow_q < SLOW_MID);
    fast_on = (fast_q < FAST_MID);
    case (mode_q)
      MODE_CONST: raw = '1;
      MODE_SLOW:  raw = {LED_W{slow_on}};
      MODE_FAST:  raw = {LED_W{fast_on}};
      MODE_CHASE: raw = ONE << chase_q;
      default:    raw = '0;
    endcase

    en      = !bs2_q || ({1'b0, pwm_q} < DUTY);
    light_d = raw & {LED_W{en}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q  <= MODE_OFF;
      slow_q  <= '0;
      fast_q  <= '0;
      chase_q <= '0;
      pwm_q   <= '0;
      bs1_q   <= 1'b0;
      bs2_q   <= 1'b0;
      light_q <= '0;
    end else begin
      mode_q  <= mode_d;
      slow_q  <= slow_d;
      fast_q  <= fast_d;
      chase_q <= chase_d;
      pwm_q   <= pwm_d;
      bs1_q   <= batt_low;
      bs2_q   <= bs1_q;
      light_q <= light_d;
    end
  end

  assign light = light_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_bike_light_ctrl.sv
// Randomised and directed bench for bike_light_ctrl against a
// time-based behavioural model of the light controller.
module tb_bike_light_ctrl;

  localparam int LED_W = 4;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int SH    = 10;
  localparam int FH    = 4;
  localparam int PB    = 2;
  localparam int DD    = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       batt_low = 1'b0;
  logic [3:0] light;
  logic [2:0] mode;

  int n_chk = 0;
  int n_fail = 0;

  bike_light_ctrl #(
    .LED_W(LED_W), .DEB_CYC(DEB), .LONG_CYC(LONG),
    .SLOW_HALF(SH), .FAST_HALF(FH), .PWM_BITS(PB), .DIM_DUTY(DD)
  ) dut (
    .clock(clock), .reset(reset), .button(button),
    .batt_low(batt_low), .light(light), .mode(mode)
  );

  always #5 clock = ~clock;

  // Model state: g = clock edges since reset; events derived from
  // the edge index at which the sampled button rose and fell.
  int       g, m_rise, m_fall, m_mode, m_chase, k, nm;
  bit       m_sb, m_long, m_short, m_b1, m_b2, m_valid = 0;
  logic [3:0] m_light;

  function automatic logic [3:0] pattern(int md, int kk, int ch);
    case (md)
      1: return 4'hF;
      2: return ((kk % (2 * SH)) < SH) ? 4'hF : 4'h0;
      3: return ((kk % (2 * FH)) < FH) ? 4'hF : 4'h0;
      4: return 4'(1 << ch);
      default: return 4'h0;
    endcase
  endfunction

  function automatic int mode_after(int md, bit s, bit l);
    if (md > 4) return 0;
    if (l) return (md == 0) ? 1 : 0;
    if (s && md != 0) return (md == 4) ? 1 : md + 1;
    return md;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      g = 0; m_sb = 0; m_rise = 0; m_fall = -100;
      m_long = 0; m_short = 0; m_mode = 0; m_chase = 0;
      m_light = 4'h0; m_b1 = 0; m_b2 = 0; m_valid = 1;
    end else begin
      k = g;
      m_light = pattern(m_mode, k, m_chase);
      if (m_b2 && (k % (1 << PB)) >= DD) m_light = 4'h0;
      nm = mode_after(m_mode, m_short, m_long);
      g = g + 1;
      if (nm == 4 && m_mode != 4) m_chase = 0;
      else if (g % FH == 0) m_chase = (m_chase + 1) % LED_W;
      m_mode = nm;
      m_long  = m_sb && (g - m_rise == LONG);
      m_short = (m_fall == g - 1) && (m_fall - m_rise < LONG);
      if (g % DEB == 0 && button != m_sb) begin
        if (button) m_rise = g; else m_fall = g;
        m_sb = button;
      end
      m_b2 = m_b1;
      m_b1 = batt_low;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      n_chk++;
      if (mode !== 3'(m_mode)) begin
        n_fail++;
        $display("FAIL model_mode t=%0t got %0d expected %0d", $time, mode, m_mode);
      end
      n_chk++;
      if (light !== m_light) begin
        n_fail++;
        $display("FAIL model_light t=%0t got %b expected %b", $time, light, m_light);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(string nm_s, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm_s, act, exp);
    end
  endtask

  task automatic press(int hi, int lo);
    button = 1'b1;
    cyc(hi);
    button = 1'b0;
    cyc(lo);
  endtask

  initial begin
    int bad;
    int t_prev, t1, t2, ntog;
    logic [3:0] lprev;
    logic [3:0] seq[$];
    int tseq[$];
    int lit, dark;

    // 1: idle after reset
    cyc(3);
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      cyc(1);
      if (mode !== 3'd0 || light !== 4'h0) bad++;
    end
    chk("idle_dark", bad, 0);

    // 2: long press turns on, release gives no event
    button = 1'b1;
    cyc(100);
    button = 1'b0;
    cyc(1);
    chk("long_mode", int'(mode), 1);
    chk("long_light", int'(light), 15);
    chk("model_pin_const", m_mode, 1);
    cyc(20);
    chk("no_short_after_long", int'(mode), 1);

    // 3: short presses cycle modes; SLOW toggles every SH cycles
    press(12, 12);
    chk("short1_slow", int'(mode), 2);
    lprev = light; ntog = 0; t1 = 0; t2 = 0; t_prev = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (light !== lprev) begin
        ntog++;
        if (ntog == 1) t1 = i;
        if (ntog == 2) t2 = i;
        lprev = light;
      end
    end
    chk("slow_toggles_seen", (ntog >= 2) ? 1 : 0, 1);
    chk("slow_half_period", t2 - t1, SH);
    press(12, 12);
    chk("short2_fast", int'(mode), 3);

    // 4: chase sequence
    button = 1'b1;
    cyc(12);
    button = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (mode == 3'd4 && $onehot(light) &&
          (seq.size() == 0 || seq[$] !== light)) begin
        seq.push_back(light);
        tseq.push_back(i);
      end
    end
    chk("short3_chase", int'(mode), 4);
    chk("chase_steps_seen", (seq.size() >= 5) ? 1 : 0, 1);
    if (seq.size() >= 5) begin
      chk("chase0", int'(seq[0]), 1);
      chk("chase1", int'(seq[1]), 2);
      chk("chase2", int'(seq[2]), 4);
      chk("chase3", int'(seq[3]), 8);
      chk("chase4", int'(seq[4]), 1);
      chk("chase_period", tseq[3] - tseq[2], FH);
    end
    press(12, 12);
    chk("short4_const", int'(mode), 1);

    // 5: low battery dims CONST to 1 slot of 4
    batt_low = 1'b1;
    cyc(6);
    lit = 0; dark = 0;
    repeat (40) begin
      cyc(1);
      if (light === 4'hF) lit++;
      if (light === 4'h0) dark++;
    end
    chk("dim_lit", lit, 10);
    chk("dim_dark", dark, 30);
    chk("dim_mode", int'(mode), 1);
    batt_low = 1'b0;
    cyc(4);

    // 6: bouncy press then reset mid-hold
    button = 1'b1; cyc(1);
    button = 1'b0; cyc(1);
    button = 1'b1; cyc(1);
    cyc(8);
    chk("bounce_no_event", int'(mode), 1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("reset_mode", int'(mode), 0);
    chk("reset_light", int'(light), 0);
    cyc(19);
    chk("held_after_reset_not_long", int'(mode), 0);
    cyc(30);
    chk("held_after_reset_long", int'(mode), 1);
    button = 1'b0;
    cyc(10);

    // randomised presses, battery flag and resets
    repeat (80) begin
      batt_low = 1'($urandom_range(0, 1));
      button = 1'b1;
      cyc($urandom_range(1, 34));
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 2));
        reset = 1'b0;
      end
      button = 1'b0;
      cyc($urandom_range(1, 30));
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
    end
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
